// File: rtl/zuc256_core_arbiter_pkg.sv
// Shared definitions for the ZUC-256 core arbiter: core widths and FSM states.
package zuc256_core_arbiter_pkg;

  localparam int ZUC256_KEY_W = 256;
  localparam int ZUC256_IV_W  = 184;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN0  = 2'd1,
    ARB_OWN1  = 2'd2,
    ARB_DRAIN = 2'd3
  } arb_state_e;

  // Ownership state that corresponds to a granted port index.
  function automatic arb_state_e own_state(input logic port);
    return port ? ARB_OWN1 : ARB_OWN0;
  endfunction

endpackage

// File: rtl/zuc256_core_arbiter_rr_arb.sv
// Two-way round-robin picker; ptr names the port favoured on a tie.
// The pointer register itself lives in the parent.
module zuc256_rr_arb (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       ptr_next
);

  // Pick one requester and point the favour at the port that lost.
  always_comb begin
    gnt      = 2'b00;
    ptr_next = ptr;
    if (en) begin
      case (req)
        2'b01: begin
          gnt      = 2'b01;
          ptr_next = 1'b1;
        end
        2'b10: begin
          gnt      = 2'b10;
          ptr_next = 1'b0;
        end
        2'b11: begin
          if (ptr) begin
            gnt      = 2'b10;
            ptr_next = 1'b0;
          end else begin
            gnt      = 2'b01;
            ptr_next = 1'b1;
          end
        end
        default: begin
          gnt      = 2'b00;
          ptr_next = ptr;
        end
      endcase
    end
  end

endmodule

// File: rtl/zuc256_core_arbiter.sv
// Shares one ZUC-256 keystream core between the MAC engine (port 0) and the
// cipher engine (port 1). Ownership is locked for a whole session; a release
// while the core is busy drains until the core reports ready again.
module zuc256_core_arbiter
  import zuc256_core_arbiter_pkg::*;
#(
  parameter int KEY_W    = ZUC256_KEY_W,
  parameter int IV_W     = ZUC256_IV_W,
  parameter int HOLD_W   = 16,
  parameter int HOLD_MAX = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_i,
  input  logic [1:0]       init_i,
  input  logic [1:0]       next_i,
  input  logic [KEY_W-1:0] key0_i,
  input  logic [KEY_W-1:0] key1_i,
  input  logic [IV_W-1:0]  iv0_i,
  input  logic [IV_W-1:0]  iv1_i,
  output logic [1:0]       gnt_o,
  output logic [1:0]       ready_o,
  output logic [31:0]      z_o,
  output logic             busy_o,
  output logic             starve_o,
  output logic             drop_o,
  output logic             core_init,
  output logic             core_next,
  output logic [KEY_W-1:0] core_key,
  output logic [IV_W-1:0]  core_iv,
  input  logic [31:0]      core_z,
  input  logic             core_ready
);

  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(HOLD_MAX);

  arb_state_e        state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              drop_q, drop_d;
  logic [1:0]        pick_gnt;
  logic              pick_ptr;
  logic              owner;
  logic              owner_strobe;
  logic              other_waiting;

  // The registered one-hot grant identifies the owner in OWN and DRAIN alike.
  assign owner         = gnt_q[1];
  assign owner_strobe  = init_i[owner] | next_i[owner];
  assign other_waiting = owner ? req_i[0] : req_i[1];

  zuc256_rr_arb u_rr_arb (
    .req      (req_i),
    .ptr      (ptr_q),
    .en       (state_q == ARB_IDLE),
    .gnt      (pick_gnt),
    .ptr_next (pick_ptr)
  );

  // Session FSM: grant from IDLE, forward owner strobes, release or drain.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    drop_d    = drop_q;
    core_init = 1'b0;
    core_next = 1'b0;
    ready_o   = 2'b00;
    case (state_q)
      ARB_IDLE: begin
        if (|req_i) begin
          state_d = own_state(pick_gnt[1]);
          gnt_d   = pick_gnt;
          ptr_d   = pick_ptr;
        end
      end
      ARB_OWN0, ARB_OWN1: begin
        core_init = init_i[owner] & core_ready;
        core_next = next_i[owner] & core_ready;
        ready_o   = owner ? {core_ready, 1'b0} : {1'b0, core_ready};
        if (owner_strobe && !core_ready) begin
          drop_d = 1'b1;
        end
        if (!req_i[owner]) begin
          if (core_ready) begin
            state_d = ARB_IDLE;
            gnt_d   = 2'b00;
          end else begin
            state_d = ARB_DRAIN;
          end
        end
      end
      ARB_DRAIN: begin
        if (core_ready) begin
          state_d = ARB_IDLE;
          gnt_d   = 2'b00;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  // Count owner cycles while the other port waits; cleared on every return to IDLE.
  always_comb begin
    hold_d = hold_q;
    if (state_d == ARB_IDLE) begin
      hold_d = '0;
    end else if (state_q != ARB_IDLE && other_waiting && !(&hold_q)) begin
      hold_d = hold_q + 1'b1;
    end
  end

  // Key/IV follow the registered grant so DRAIN keeps the owner's values on the core.
  always_comb begin
    core_key = '0;
    core_iv  = '0;
    if (gnt_q[0]) begin
      core_key = key0_i;
      core_iv  = iv0_i;
    end else if (gnt_q[1]) begin
      core_key = key1_i;
      core_iv  = iv1_i;
    end
  end

  assign gnt_o    = gnt_q;
  assign z_o      = (|gnt_q) ? core_z : 32'd0;
  assign busy_o   = (state_q != ARB_IDLE);
  assign starve_o = (hold_q >= HOLD_LIMIT);
  assign drop_o   = drop_q;

  // State registers; reset abandons any session without telling the core.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      gnt_q   <= 2'b00;
      ptr_q   <= 1'b0;
      hold_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      drop_q  <= drop_d;
    end
  end

endmodule
